// File: rtl/dcache_pkg.sv
// Shared dcache definitions for the tag-array write controller.
//   tagwr_state_e     : write-controller FSM states
//   DCACHE_SETS       : number of sets swept by an invalidation pass
//   TAG_INVALID_ENTRY : value written to every way during a sweep
`ifndef DCACHE_WAY_NUM
`define DCACHE_WAY_NUM 4
`endif

package dcache_pkg;

   localparam int DCACHE_ADDR_WIDTH = 6;
   localparam int DCACHE_DATA_WIDTH = 44;
   localparam int DCACHE_SETS       = 2**DCACHE_ADDR_WIDTH;

   localparam logic [DCACHE_DATA_WIDTH-1:0] TAG_INVALID_ENTRY = '0;

   typedef enum logic [1:0] {
      INIT  = 2'd0,
      IDLE  = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } tagwr_state_e;

endpackage

// File: rtl/dcache_tag_sweeper.sv
// Set counter for the tag-array invalidation sweep, shared by the
// post-reset pass and the flush pass.
//   clock, reset : clock and synchronous active-high reset (reset starts a pass)
//   start        : begin a new pass at set 0 on the next cycle
//   active       : a set write is issued this cycle for set idx
//   idx          : set currently being invalidated
//   done         : one-cycle pulse the cycle after the final set was issued
module dcache_tag_sweeper
   import dcache_pkg::*;
#(
   parameter int ADDR_WIDTH = DCACHE_ADDR_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   output logic                  active,
   output logic [ADDR_WIDTH-1:0] idx,
   output logic                  done
);

   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  active_q, active_d;
   logic                  done_q, done_d;
   logic                  last;

   assign last = active_q && (cnt_q == {ADDR_WIDTH{1'b1}});

   // The counter wraps naturally from all-ones to zero; that wrap ends the pass.
   always_comb begin
      cnt_d    = cnt_q;
      active_d = active_q;
      done_d   = last;
      if (start) begin
         cnt_d    = '0;
         active_d = 1'b1;
      end else if (active_q) begin
         cnt_d = cnt_q + 1'b1;
         if (last) active_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q    <= '0;
         active_q <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         active_q <= active_d;
         done_q   <= done_d;
      end
   end

   assign active = active_q;
   assign idx    = cnt_q;
   assign done   = done_q;

endmodule

// File: rtl/dcache_tagarray_wrctrl.sv
// Sole driver of the dcache tag-array write port. Arbitrates refill writes
// and store-path metadata writes, and invalidates the whole array after
// reset and on flush request.
//   clock, reset            : clock, synchronous active-high reset
//   refill_*                : miss-unit write request (valid/ready + way/idx/data)
//   meta_*                  : store-path metadata write request
//   flush_req / flush_ack   : level flush request / one-cycle completion pulse
//   tag_ready               : array contents valid, readers may issue
//   writeport_*             : registered write port to the tag array
//
// state | meaning
// INIT  | post-reset invalidation sweep, no grants
// IDLE  | array valid, grants refill > meta, may start a flush
// FLUSH | flush invalidation sweep, no grants
// DONE  | flush complete, flush_ack pulse
`ifndef DCACHE_WAY_NUM
`define DCACHE_WAY_NUM 4
`endif

module dcache_tagarray_wrctrl
   import dcache_pkg::*;
#(
   parameter int DATA_WIDTH = DCACHE_DATA_WIDTH,
   parameter int ADDR_WIDTH = DCACHE_ADDR_WIDTH
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       refill_valid,
   output logic                       refill_ready,
   input  logic [`DCACHE_WAY_NUM-1:0] refill_way,
   input  logic [ADDR_WIDTH-1:0]      refill_idx,
   input  logic [DATA_WIDTH-1:0]      refill_data,
   input  logic                       meta_valid,
   output logic                       meta_ready,
   input  logic [`DCACHE_WAY_NUM-1:0] meta_way,
   input  logic [ADDR_WIDTH-1:0]      meta_idx,
   input  logic [DATA_WIDTH-1:0]      meta_data,
   input  logic                       flush_req,
   output logic                       flush_ack,
   output logic                       tag_ready,
   output logic                       writeport_wr_en,
   output logic [`DCACHE_WAY_NUM-1:0] writeport_wr_way,
   output logic [ADDR_WIDTH-1:0]      writeport_wr_idx,
   output logic [DATA_WIDTH-1:0]      writeport_wr_data
);

   tagwr_state_e state_q, state_d;

   logic                       sweep_active;
   logic [ADDR_WIDTH-1:0]      sweep_idx;
   logic                       sweep_done;
   logic                       flush_go;

   logic                       wr_en_q,   wr_en_d;
   logic [`DCACHE_WAY_NUM-1:0] wr_way_q,  wr_way_d;
   logic [ADDR_WIDTH-1:0]      wr_idx_q,  wr_idx_d;
   logic [DATA_WIDTH-1:0]      wr_data_q, wr_data_d;

   // Flush yields to any pending request so in-flight traffic lands first.
   assign flush_go = (state_q == IDLE) && flush_req && !refill_valid && !meta_valid;

   dcache_tag_sweeper #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_sweeper (
      .clock  (clock),
      .reset  (reset),
      .start  (flush_go),
      .active (sweep_active),
      .idx    (sweep_idx),
      .done   (sweep_done)
   );

   always_ff @(posedge clock) begin
      if (reset) state_q <= INIT;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         INIT:    if (sweep_done) state_d = IDLE;
         IDLE:    if (flush_go)   state_d = FLUSH;
         FLUSH:   if (sweep_done) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = INIT;
      endcase
   end

   always_comb begin
      refill_ready = 1'b0;
      meta_ready   = 1'b0;
      tag_ready    = 1'b0;
      flush_ack    = 1'b0;
      case (state_q)
         IDLE: begin
            refill_ready = refill_valid;
            meta_ready   = meta_valid && !refill_valid;
            tag_ready    = !flush_go;
         end
         DONE: begin
            tag_ready = 1'b1;
            flush_ack = 1'b1;
         end
         default: ;
      endcase

      wr_en_d   = 1'b0;
      wr_way_d  = '0;
      wr_idx_d  = '0;
      wr_data_d = '0;
      if (sweep_active) begin
         wr_en_d   = 1'b1;
         wr_way_d  = '1;
         wr_idx_d  = sweep_idx;
         wr_data_d = DATA_WIDTH'(TAG_INVALID_ENTRY);
      end else if (refill_ready) begin
         wr_en_d   = 1'b1;
         wr_way_d  = refill_way;
         wr_idx_d  = refill_idx;
         wr_data_d = refill_data;
      end else if (meta_ready) begin
         wr_en_d   = 1'b1;
         wr_way_d  = meta_way;
         wr_idx_d  = meta_idx;
         wr_data_d = meta_data;
      end
   end

   // Reset discards any write captured in the previous cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_en_q   <= 1'b0;
         wr_way_q  <= '0;
         wr_idx_q  <= '0;
         wr_data_q <= '0;
      end else begin
         wr_en_q   <= wr_en_d;
         wr_way_q  <= wr_way_d;
         wr_idx_q  <= wr_idx_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign writeport_wr_en   = wr_en_q;
   assign writeport_wr_way  = wr_way_q;
   assign writeport_wr_idx  = wr_idx_q;
   assign writeport_wr_data = wr_data_q;

endmodule
